// File: rtl/char_draw_arbiter.sv
// Round-robin arbiter that shares one LCD glyph renderer between NUM_REQ text sources.
// req_ready/req_done are same-cycle pulses; the glyph fields are latched at accept.
module char_draw_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 init_done,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_ascii,
  input  logic [9*NUM_REQ-1:0] req_x,
  input  logic [9*NUM_REQ-1:0] req_y,
  input  logic [NUM_REQ-1:0]   req_size,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 show_char_flag,
  output logic [6:0]           ascii_num,
  output logic [8:0]           start_x,
  output logic [8:0]           start_y,
  output logic                 en_size,
  input  logic                 show_char_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [GW:0]      NUM_REQ_W = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0]    LAST_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT
  } state_t;

  state_t            state_reg, state_next;
  logic [GW-1:0]     grant_reg, grant_next;
  logic [GW-1:0]     last_grant_reg, last_grant_next;
  logic [6:0]        ascii_reg, ascii_next;
  logic [8:0]        x_reg, x_next;
  logic [8:0]        y_reg, y_next;
  logic              size_reg, size_next;
  logic [CNT_W-1:0]  wd_reg, wd_next;
  logic              terr_reg, terr_next;

  logic              accept;
  logic              finish;

  logic [6:0]        ascii_arr [NUM_REQ];
  logic [8:0]        x_arr     [NUM_REQ];
  logic [8:0]        y_arr     [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign ascii_arr[gi] = req_ascii[7*gi +: 7];
      assign x_arr[gi]     = req_x[9*gi +: 9];
      assign y_arr[gi]     = req_y[9*gi +: 9];
    end
  endgenerate

  // Rotate the valid vector so bit 0 is the requester just after last_grant.
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [GW:0]          rot_base;
  logic [GW-1:0]        rot_off;
  logic                 rot_hit;
  logic [GW:0]          pick_sum;
  logic [GW-1:0]        pick_idx;

  assign dbl_valid = {req_valid, req_valid};
  assign rot_base  = {1'b0, last_grant_reg} + (GW+1)'(1);
  assign rot_valid = dbl_valid[rot_base +: NUM_REQ];

  always_comb begin
    rot_hit = 1'b0;
    rot_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        rot_hit = 1'b1;
        rot_off = GW'(k);
      end
    end
  end

  assign pick_sum = rot_base + {1'b0, rot_off};
  assign pick_idx = (pick_sum >= NUM_REQ_W) ? GW'(pick_sum - NUM_REQ_W) : GW'(pick_sum);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= LAST_INIT;
      ascii_reg      <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      size_reg       <= 1'b0;
      wd_reg         <= '0;
      terr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      ascii_reg      <= ascii_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      size_reg       <= size_next;
      wd_reg         <= wd_next;
      terr_reg       <= terr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    ascii_next      = ascii_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    size_next       = size_reg;
    wd_next         = wd_reg;
    terr_next       = terr_reg;
    accept          = 1'b0;
    finish          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (init_done && rot_hit) begin
          accept     = 1'b1;
          grant_next = pick_idx;
          ascii_next = ascii_arr[pick_idx];
          x_next     = x_arr[pick_idx];
          y_next     = y_arr[pick_idx];
          size_next  = req_size[pick_idx];
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_next = '0;
        if (!init_done) begin
          last_grant_next = grant_reg;
          state_next      = ST_IDLE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Losing init_done aborts silently; the requester must present again.
        if (!init_done) begin
          last_grant_next = grant_reg;
          state_next      = ST_IDLE;
        end else if (show_char_done) begin
          finish          = 1'b1;
          last_grant_next = grant_reg;
          state_next      = ST_IDLE;
        end else if (wd_reg == WD_LAST) begin
          finish          = 1'b1;
          terr_next       = 1'b1;
          last_grant_next = grant_reg;
          state_next      = ST_IDLE;
        end else if (wd_reg != {CNT_W{1'b1}}) begin
          wd_next = wd_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // req_ready is gated by the reset so every output reads 0 while reset is held.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_pulse
      assign req_ready[gi] = sys_rst_n & accept & (pick_idx == GW'(gi));
      assign req_done[gi]  = finish & (grant_reg == GW'(gi));
    end
  endgenerate

  assign show_char_flag = (state_reg == ST_LAUNCH);
  assign busy           = (state_reg != ST_IDLE);
  assign ascii_num      = ascii_reg;
  assign start_x        = x_reg;
  assign start_y        = y_reg;
  assign en_size        = size_reg;
  assign timeout_err    = terr_reg;

endmodule

// File: tb/tb_char_draw_arbiter.sv
// Directed plus randomized bench for char_draw_arbiter; a round-robin reference model
// predicts every grant, latched field, done pulse and the sticky timeout flag.
module tb_char_draw_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           sys_clk        = 1'b0;
  logic           sys_rst_n      = 1'b0;
  logic           init_done      = 1'b1;
  logic [N-1:0]   req_valid      = '1;
  logic [7*N-1:0] req_ascii      = '0;
  logic [9*N-1:0] req_x          = '0;
  logic [9*N-1:0] req_y          = '0;
  logic [N-1:0]   req_size       = '0;
  logic           show_char_done = 1'b1;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_done;
  logic           show_char_flag;
  logic [6:0]     ascii_num;
  logic [8:0]     start_x;
  logic [8:0]     start_y;
  logic           en_size;
  logic           busy;
  logic           timeout_err;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_txn  = 0;
  int m_last = N - 1;
  bit m_terr = 1'b0;

  char_draw_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .init_done      (init_done),
    .req_valid      (req_valid),
    .req_ascii      (req_ascii),
    .req_x          (req_x),
    .req_y          (req_y),
    .req_size       (req_size),
    .req_ready      (req_ready),
    .req_done       (req_done),
    .show_char_flag (show_char_flag),
    .ascii_num      (ascii_num),
    .start_x        (start_x),
    .start_y        (start_y),
    .en_size        (en_size),
    .show_char_done (show_char_done),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first valid index after the last grant, wrapping modulo N.
  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_glyph(input int i, input logic [6:0] a, input logic [8:0] x,
                           input logic [8:0] y, input logic s);
    req_ascii[7*i +: 7] = a;
    req_x[9*i +: 9]     = x;
    req_y[9*i +: 9]     = y;
    req_size[i]         = s;
  endtask

  task automatic rand_fields();
    req_ascii = 28'($urandom());
    req_x     = 36'({$urandom(), $urandom()});
    req_y     = 36'({$urandom(), $urandom()});
    req_size  = 4'($urandom());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_done"},  32'(req_done), 32'(0));
    chk({tag, "_flag"},  32'(show_char_flag), 32'(0));
    chk({tag, "_busy"},  32'(busy), 32'(0));
    chk({tag, "_ascii"}, 32'(ascii_num), 32'(0));
    chk({tag, "_x"},     32'(start_x), 32'(0));
    chk({tag, "_y"},     32'(start_y), 32'(0));
    chk({tag, "_size"},  32'(en_size), 32'(0));
    chk({tag, "_terr"},  32'(timeout_err), 32'(0));
  endtask

  // One render: accept this cycle, done in WAIT cycle 'delay' (0 = never, watchdog fires).
  task automatic run_one(input int delay, input bit spur);
    int           g;
    logic [N-1:0] oh;
    logic [N-1:0] exp_done;
    logic [6:0]   e_ascii;
    logic [8:0]   e_x, e_y;
    logic         e_size;
    bit           done_seen;
    g  = model_pick(req_valid, m_last);
    oh = '0;
    oh[g] = 1'b1;
    e_ascii = req_ascii[7*g +: 7];
    e_x     = req_x[9*g +: 9];
    e_y     = req_y[9*g +: 9];
    e_size  = req_size[g];
    @(negedge sys_clk);
    chk("ready_accept", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 32'(0));
    @(posedge sys_clk); #1;
    show_char_done = spur;
    rand_fields();
    @(negedge sys_clk);
    chk("flag_launch", 32'(show_char_flag), 32'(1));
    chk("ascii_num", 32'(ascii_num), 32'(e_ascii));
    chk("start_x", 32'(start_x), 32'(e_x));
    chk("start_y", 32'(start_y), 32'(e_y));
    chk("en_size", 32'(en_size), 32'(e_size));
    chk("done_launch", 32'(req_done), 32'(0));
    done_seen = 1'b0;
    for (int c = 1; c <= TO + 2 && !done_seen; c++) begin
      @(posedge sys_clk); #1;
      show_char_done = (delay > 0 && c == delay);
      @(negedge sys_clk);
      done_seen = (delay > 0) ? (c == delay) : (c == TO);
      exp_done  = done_seen ? oh : '0;
      chk("done_wait", 32'(req_done), 32'(exp_done));
      chk("flag_wait", 32'(show_char_flag), 32'(0));
      chk("ready_wait", 32'(req_ready), 32'(0));
    end
    chk("hold_ascii", 32'(ascii_num), 32'(e_ascii));
    chk("hold_x", 32'(start_x), 32'(e_x));
    m_last = g;
    if (delay == 0) m_terr = 1'b1;
    @(posedge sys_clk); #1;
    show_char_done = 1'b0;
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("busy_after", 32'(busy), 32'(0));
    n_txn++;
    $display("txn %0d: grant %0d ascii %0d x %0d y %0d size %0d delay %0d terr %0d",
             n_txn, g, e_ascii, e_x, e_y, e_size, delay, m_terr);
  endtask

  initial begin
    int           g;
    logic [N-1:0] oh;
    rand_fields();

    // Reset with requests and a done pulse present: every output must stay 0.
    @(negedge sys_clk);
    chk_all_zero("reset");
    @(posedge sys_clk); #1;
    sys_rst_n      = 1'b1;
    show_char_done = 1'b0;

    // Single request with known glyph.
    req_valid = 4'b0001;
    set_glyph(0, 7'd16, 9'd128, 9'd32, 1'b1);
    run_one(5, 1'b0);

    // All requesters held: rotation through every index.
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) run_one(2, 1'b0);

    // Skip over idle indices on wrap.
    req_valid = 4'b0010;
    run_one(2, 1'b0);
    req_valid = 4'b0011;
    run_one(2, 1'b0);
    run_one(2, 1'b0);

    // Watchdog expiry, then normal service with the sticky flag still set.
    req_valid = 4'b1000;
    run_one(0, 1'b0);
    req_valid = 4'b0001;
    run_one(3, 1'b1);

    // Randomized traffic with occasional idle gaps and spurious done in LAUNCH.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        @(negedge sys_clk);
        chk("ready_gap", 32'(req_ready), 32'(0));
        @(posedge sys_clk); #1;
      end
      req_valid = 4'($urandom_range(1, 15));
      rand_fields();
      run_one(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)),
              1'($urandom_range(0, 1)));
    end

    // init_done gating, then loss of init_done during WAIT.
    req_valid = 4'b0100;
    init_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("ready_gated", 32'(req_ready), 32'(0));
      chk("busy_gated", 32'(busy), 32'(0));
      @(posedge sys_clk); #1;
    end
    init_done = 1'b1;
    g  = model_pick(req_valid, m_last);
    oh = '0;
    oh[g] = 1'b1;
    @(negedge sys_clk);
    chk("ready_ungated", 32'(req_ready), 32'(oh));
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk("flag_abort_run", 32'(show_char_flag), 32'(1));
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    init_done = 1'b0;
    @(negedge sys_clk);
    chk("done_abort", 32'(req_done), 32'(0));
    chk("busy_abort", 32'(busy), 32'(1));
    @(posedge sys_clk); #1;
    m_last = g;
    @(negedge sys_clk);
    chk("busy_aborted", 32'(busy), 32'(0));
    chk("done_aborted", 32'(req_done), 32'(0));
    chk("ready_aborted", 32'(req_ready), 32'(0));
    @(posedge sys_clk); #1;
    init_done = 1'b1;
    run_one(2, 1'b0);

    // Spurious done while idle.
    req_valid = '0;
    @(posedge sys_clk); #1;
    show_char_done = 1'b1;
    @(negedge sys_clk);
    chk("spur_done", 32'(req_done), 32'(0));
    chk("spur_busy", 32'(busy), 32'(0));
    @(posedge sys_clk); #1;
    show_char_done = 1'b0;
    @(negedge sys_clk);
    chk("spur_after_busy", 32'(busy), 32'(0));
    chk("spur_after_flag", 32'(show_char_flag), 32'(0));

    // Asynchronous reset in the middle of WAIT.
    @(posedge sys_clk); #1;
    req_valid = 4'b1000;
    rand_fields();
    g  = model_pick(req_valid, m_last);
    oh = '0;
    oh[g] = 1'b1;
    @(negedge sys_clk);
    chk("ready_pre_rst", 32'(req_ready), 32'(oh));
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk("busy_pre_rst", 32'(busy), 32'(1));
    show_char_done = 1'b1;
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(posedge sys_clk); #1;
    sys_rst_n      = 1'b1;
    show_char_done = 1'b0;
    m_last         = N - 1;
    m_terr         = 1'b0;
    req_valid      = 4'b1111;
    run_one(1, 1'b0);
    run_one(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: observed no completion, required $finish before 2 ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule
